board_draw_ctrl: RTL and testbench
==================================

BOARD_DRAW_CTRL -- requirements
Module: board_draw_ctrl

Interface
REQ-001 Parameter ORIGIN_X, default 32: board left edge pixel column.
REQ-002 Parameter ORIGIN_Y, default 12: board top edge pixel row.
REQ-003 Parameter CELL, default 12: cell edge length in pixels; 8x8 cells.
REQ-004 Port CLOCK_50  input  1  sole clock, all state on rising edge.
REQ-005 Port resetn  input  1  asynchronous, active-low reset.
REQ-006 Port req_valid  input  1  single-cell draw request.
REQ-007 Port req_ready  output  1  request accepted when req_valid && req_ready at a clock edge.
REQ-008 Port req_row  input  3  cell row 0..7.
REQ-009 Port req_col  input  3  cell column 0..7.
REQ-010 Port req_piece  input  2  00 empty, 01 black, 10 white, 11 treated as empty.
REQ-011 Port req_cursor  input  1  cell drawn with cursor border.
REQ-012 Port clear_req  input  1  one-cycle pulse: redraw whole board empty.
REQ-013 Port x  output  8  VGA pixel column.
REQ-014 Port y  output  7  VGA pixel row.
REQ-015 Port colour  output  3  RGB pixel colour.
REQ-016 Port plot  output  1  write strobe to VGA adapter.
REQ-017 Port busy  output  1  high in any non-IDLE state.
REQ-018 Port done  output  1  one-cycle pulse after the last pixel of a job.

Function
REQ-019 FSM states SHALL be IDLE, CELL, CLEAR, FINISH.
REQ-020 req_ready SHALL be high only in IDLE with no clear pending and clear_req low.
REQ-021 IDLE: pending or incoming clear -> CLEAR (priority over req_valid); else accepted request -> CELL with row/col/piece/cursor latched.
REQ-022 Pixel scan: px fastest 0..CELL-1, then py 0..CELL-1; one pixel per cycle, plot high every cycle in CELL and CLEAR.
REQ-023 First plot SHALL occur the cycle after acceptance; a cell takes exactly CELL*CELL (144) plot cycles.
REQ-024 CLEAR SHALL draw all 64 cells, row-major from (0,0), piece empty, no cursor: 9216 contiguous plot cycles.
REQ-025 x = ORIGIN_X + col*CELL + px, y = ORIGIN_Y + row*CELL + py, no wrap at defaults (max x 127, y 107).
REQ-026 Colour: px==0 or py==0 -> 3'b100 if cursor else 3'b000; piece black/white with px,py in 3..8 -> 3'b000/3'b111; else 3'b010.
REQ-027 After the last pixel SHALL enter FINISH: plot low, done high one cycle, then IDLE.
REQ-028 clear_req while busy SHALL set a clear-pending flag, serviced on return to IDLE; multiple pulses collapse to one.
REQ-029 Request inputs while not ready SHALL be ignored; no queueing of cell requests.
REQ-030 Outside CELL/CLEAR, plot SHALL be low; x, y, colour hold last values.

Reset
REQ-031 resetn low SHALL immediately force IDLE, counters 0, clear-pending 0, x=0, y=0, colour=0, plot=0, busy=0, done=0.
REQ-032 Reset mid-job SHALL abandon the job; no plot after release until a new request.
REQ-033 req_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-034 Shared package reversi_pkg SHALL hold piece encodings, colour constants (GREEN, BLACK, WHITE, RED) and board size 8.
REQ-035 Sub-module cell_pixel_gen SHALL hold the combinational px/py/piece/cursor -> colour mapping; FSM and counters stay in board_draw_ctrl.

Verification
REQ-036 Reset, request row 2 col 3 piece 01 cursor 0 -> 144 plots, first (68,36) colour 000, pixel (71,39) 000, (69,37) 010, done one cycle after (79,47).
REQ-037 Request row 7 col 7 piece 10 cursor 1 -> (116,96) colour 100, (120,100) 111, last plot (127,107), no wrap.
REQ-038 clear_req and req_valid same cycle in IDLE -> clear runs (9216 plots), req_ready 0 that cycle, cell request not executed.
REQ-039 clear_req pulsed twice during cell job -> cell completes, done, one 9216-plot clear follows, then done, then IDLE.
REQ-040 resetn asserted at plot 50 of a cell -> plot, busy 0 immediately; no further plots; req_ready 1 after release.

Source files
------------

// File: rtl/reversi_pkg.sv
// Shared reversi definitions: piece encodings, VGA colours, board size and draw FSM states.
package reversi_pkg;

  localparam int unsigned BOARD_SIZE = 8;

  localparam logic [1:0] PIECE_EMPTY = 2'b00;
  localparam logic [1:0] PIECE_BLACK = 2'b01;
  localparam logic [1:0] PIECE_WHITE = 2'b10;

  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StCell,
    StClear,
    StFinish
  } draw_state_t;

endpackage

// File: rtl/board_draw_ctrl_if.sv
// Request handshake plus VGA pixel/status bundle of the board drawing controller.
interface board_draw_ctrl_if;

  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_row;
  logic [2:0] req_col;
  logic [1:0] req_piece;
  logic       req_cursor;
  logic       clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_row, req_col, req_piece, req_cursor, clear_req,
    input  req_ready, x, y, colour, plot, busy, done
  );

  modport slave (
    input  req_valid, req_row, req_col, req_piece, req_cursor, clear_req,
    output req_ready, x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/cell_pixel_gen.sv
// Combinational colour of one pixel inside a board cell: border, disc or background.
module cell_pixel_gen
  import reversi_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [1:0]    piece,
  input  logic          cursor,
  output logic [2:0]    colour
);

  logic in_disc;

  always_comb begin
    in_disc = (32'(px) >= 32'd3) && (32'(px) <= 32'd8) &&
              (32'(py) >= 32'd3) && (32'(py) <= 32'd8);
    colour  = GREEN;
    // Border takes priority over the disc; piece 11 falls through to background.
    if (px == '0 || py == '0) begin
      colour = cursor ? RED : BLACK;
    end else if (in_disc && piece == PIECE_BLACK) begin
      colour = BLACK;
    end else if (in_disc && piece == PIECE_WHITE) begin
      colour = WHITE;
    end
  end

endmodule

// File: rtl/board_draw_ctrl.sv
// Draws single board cells or clears the whole 8x8 board, one VGA pixel per clock.
module board_draw_ctrl
  import reversi_pkg::*;
#(
  parameter int unsigned ORIGIN_X = 32,
  parameter int unsigned ORIGIN_Y = 12,
  parameter int unsigned CELL     = 12
) (
  input logic              CLOCK_50,
  input logic              resetn,
  board_draw_ctrl_if.slave bus
);

  localparam int unsigned CW = (CELL > 1) ? $clog2(CELL) : 1;

  draw_state_t state_q, state_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic [2:0]    row_q, row_d, col_q, col_d;
  logic [1:0]    piece_q, piece_d;
  logic          cursor_q, cursor_d;
  logic          clear_pend_q, clear_pend_d;
  logic [7:0]    x_q, x_calc;
  logic [6:0]    y_q, y_calc;
  logic [2:0]    colour_q, colour_calc;
  logic          plotting, last_pix;

  cell_pixel_gen #(
    .CW(CW)
  ) u_pixel_gen (
    .px    (px_q),
    .py    (py_q),
    .piece (piece_q),
    .cursor(cursor_q),
    .colour(colour_calc)
  );

  assign x_calc   = 8'(ORIGIN_X + CELL * 32'(col_q) + 32'(px_q));
  assign y_calc   = 7'(ORIGIN_Y + CELL * 32'(row_q) + 32'(py_q));
  assign plotting = (state_q == StCell) || (state_q == StClear);
  assign last_pix = (px_q == CW'(CELL - 1)) && (py_q == CW'(CELL - 1));

  assign bus.req_ready = (state_q == StIdle) && !clear_pend_q && !bus.clear_req;
  assign bus.plot      = plotting;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StFinish);
  assign bus.x         = plotting ? x_calc : x_q;
  assign bus.y         = plotting ? y_calc : y_q;
  assign bus.colour    = plotting ? colour_calc : colour_q;

  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    row_d        = row_q;
    col_d        = col_q;
    piece_d      = piece_q;
    cursor_d     = cursor_q;
    clear_pend_d = clear_pend_q | (bus.clear_req && state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (clear_pend_q || bus.clear_req) begin
          state_d      = StClear;
          clear_pend_d = 1'b0;
          px_d         = '0;
          py_d         = '0;
          row_d        = '0;
          col_d        = '0;
          piece_d      = PIECE_EMPTY;
          cursor_d     = 1'b0;
        end else if (bus.req_valid) begin
          state_d  = StCell;
          px_d     = '0;
          py_d     = '0;
          row_d    = bus.req_row;
          col_d    = bus.req_col;
          piece_d  = bus.req_piece;
          cursor_d = bus.req_cursor;
        end
      end
      StCell, StClear: begin
        if (px_q != CW'(CELL - 1)) begin
          px_d = px_q + 1'b1;
        end else begin
          px_d = '0;
          py_d = (py_q == CW'(CELL - 1)) ? '0 : py_q + 1'b1;
        end
        if (last_pix) begin
          if (state_q == StCell) begin
            state_d = StFinish;
          end else if (col_q == 3'(BOARD_SIZE - 1)) begin
            col_d = '0;
            if (row_q == 3'(BOARD_SIZE - 1)) state_d = StFinish;
            else                             row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      px_q         <= '0;
      py_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      piece_q      <= PIECE_EMPTY;
      cursor_q     <= 1'b0;
      clear_pend_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      row_q        <= row_d;
      col_q        <= col_d;
      piece_q      <= piece_d;
      cursor_q     <= cursor_d;
      clear_pend_q <= clear_pend_d;
      if (plotting) begin
        x_q      <= x_calc;
        y_q      <= y_calc;
        colour_q <= colour_calc;
      end
    end
  end

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Directed and randomised bench for board_draw_ctrl against a pixel-list reference model.
module tb_board_draw_ctrl;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  board_draw_ctrl_if bus ();

  board_draw_ctrl dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected plots, each packed as {x[7:0], y[6:0], colour[2:0]}.
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_colour(int px, int py, int piece, bit cursor);
    if (px == 0 || py == 0) return cursor ? 3'b100 : 3'b000;
    if (px >= 3 && px <= 8 && py >= 3 && py <= 8) begin
      if (piece == 1) return 3'b000;
      if (piece == 2) return 3'b111;
    end
    return 3'b010;
  endfunction

  task automatic push_cell(input int row, input int col, input int piece, input bit cursor);
    for (int py = 0; py < 12; py++)
      for (int px = 0; px < 12; px++)
        exp_q.push_back({8'(32 + col * 12 + px), 7'(12 + row * 12 + py),
                         model_colour(px, py, piece, cursor)});
  endtask

  task automatic push_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) push_cell(r, c, 0, 1'b0);
  endtask

  // Called at a negedge; drives one request cycle and leaves at the next negedge.
  task automatic send_req(input int row, input int col, input int piece, input bit cursor,
                          input bit clr);
    bus.req_valid  = 1'b1;
    bus.req_row    = 3'(row);
    bus.req_col    = 3'(col);
    bus.req_piece  = 2'(piece);
    bus.req_cursor = cursor;
    bus.clear_req  = clr;
    #1;
    check("req_ready at request", bus.req_ready, {31'b0, !clr});
    if (clr) push_board();
    else     push_cell(row, col, piece, cursor);
    @(negedge CLOCK_50);
    bus.req_valid = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic run_job(input string tag, input int max_lat, input int clr_a, input int clr_b,
                         input int junk);
    int lat = 0;
    int n = 0;
    logic [17:0] last = '0;
    while (!bus.plot && lat < max_lat) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check({tag, " start"}, bus.plot, 1);
    while (bus.plot && exp_q.size() > 0) begin
      check({tag, " pixel"}, {bus.x, bus.y, bus.colour}, exp_q[0]);
      last = exp_q.pop_front();
      bus.clear_req = (n == clr_a) || (n == clr_b);
      if (n == junk) begin
        bus.req_valid  = 1'b1;
        bus.req_row    = 3'($urandom);
        bus.req_col    = 3'($urandom);
        bus.req_piece  = 2'($urandom);
        bus.req_cursor = 1'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
      n++;
      @(negedge CLOCK_50);
    end
    bus.clear_req = 1'b0;
    bus.req_valid = 1'b0;
    check({tag, " missing plots"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, " finish plot/done/busy"}, {bus.plot, bus.done, bus.busy}, 3'b011);
    check({tag, " hold xyc"}, {bus.x, bus.y, bus.colour}, last);
    @(negedge CLOCK_50);
    check({tag, " idle plot/done/busy"}, {bus.plot, bus.done, bus.busy}, 3'b000);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge CLOCK_50);
      if (bus.plot) seen++;
    end
    check({tag, " stray plots"}, seen, 0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_row    = '0;
    bus.req_col    = '0;
    bus.req_piece  = '0;
    bus.req_cursor = 1'b0;
    bus.clear_req  = 1'b0;

    // Reset state
    repeat (2) @(negedge CLOCK_50);
    check("reset outputs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
    resetn = 1'b1;
    #1;
    check("ready after reset", bus.req_ready, 1);
    @(negedge CLOCK_50);

    // Black piece at row 2 col 3, first plot the cycle after acceptance
    send_req(2, 3, 1, 1'b0, 1'b0);
    run_job("cell r2c3", 0, -1, -1, -1);
    check("ready after cell", bus.req_ready, 1);

    // Corner cell with cursor and white piece, no coordinate wrap
    send_req(7, 7, 2, 1'b1, 1'b0);
    run_job("cell r7c7", 0, -1, -1, 40);
    quiet("after r7c7", 4);

    // Clear and request together: clear wins, request dropped
    send_req(4, 4, 1, 1'b1, 1'b1);
    run_job("clear+req", 0, -1, -1, -1);
    quiet("after clear+req", 20);

    // Two clear pulses during a cell job collapse to one clear afterwards
    send_req(5, 1, 2, 1'b0, 1'b0);
    run_job("cell r5c1", 0, 10, 20, -1);
    check("pending blocks ready", bus.req_ready, 0);
    push_board();
    run_job("pending clear", 1, -1, -1, -1);
    quiet("after pending clear", 20);
    check("ready after pending clear", bus.req_ready, 1);

    // Randomised cells
    for (int i = 0; i < 6; i++) begin
      send_req($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(3, 0),
               1'($urandom), 1'b0);
      run_job("random cell", 0, -1, -1, (i == 2) ? 30 : -1);
      quiet("after random cell", 3);
    end

    // Reset in the middle of a cell
    send_req(3, 6, 1, 1'b1, 1'b0);
    repeat (50) @(negedge CLOCK_50);
    check("plot before mid reset", bus.plot, 1);
    resetn = 1'b0;
    #1;
    check("mid reset plot/busy/done", {bus.plot, bus.busy, bus.done}, 3'b000);
    check("mid reset xyc", {bus.x, bus.y, bus.colour}, 0);
    exp_q.delete();
    @(negedge CLOCK_50);
    resetn = 1'b1;
    #1;
    check("ready after mid reset", bus.req_ready, 1);
    quiet("after mid reset", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
